// File: rtl/instr_receiver.sv
// Instruction receiver: address-filters strobed instructions from self/right/left,
// arbitrates them round-robin into a show-ahead FIFO with source tags, counts drops.
module instr_receiver #(
  parameter int          WIDTH     = 32,
  parameter logic [7:0]  NODE_ADDR = 8'h00,
  parameter int          DEPTH     = 4,
  parameter int          CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 check_self,
  input  logic                 check_right,
  input  logic                 check_left,
  input  logic [WIDTH-1:0]     instr_self,
  input  logic [WIDTH-1:0]     instr_right,
  input  logic [WIDTH-1:0]     instr_left,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_instr,
  output logic [1:0]           out_src,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SRC_SELF  = 2'b00,
    SRC_RIGHT = 2'b01,
    SRC_LEFT  = 2'b10
  } src_e;

  src_e rr_ptr, rr_next;

  logic [2:0]       strobe;
  logic [WIDTH-1:0] in_data   [3];
  logic [2:0]       accept;
  logic [2:0]       hold_valid;
  logic [WIDTH-1:0] hold_data [3];
  logic [2:0]       drained;
  logic [2:0]       dropped;

  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             full, pop, can_push, grant, found;
  logic [1:0]       gidx;
  logic [1:0]       order [3];
  logic [1:0]       ndrops;
  logic [CNT_WIDTH+1:0] drop_sum;

  assign strobe     = {check_left, check_right, check_self};
  assign in_data[0] = instr_self;
  assign in_data[1] = instr_right;
  assign in_data[2] = instr_left;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign can_push  = !full || pop;
  assign out_instr = out_valid ? mem[rd_ptr][WIDTH-1:0]       : '0;
  assign out_src   = out_valid ? mem[rd_ptr][WIDTH+1:WIDTH]   : '0;

  always_comb begin
    accept  = '0;
    dropped = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      accept[i]  = strobe[i] && ((in_data[i][WIDTH-1 -: 8] == NODE_ADDR) ||
                                 (in_data[i][WIDTH-1 -: 8] == 8'hFF));
      dropped[i] = accept[i] && hold_valid[i] && !drained[i];
    end
    ndrops   = 2'(dropped[0]) + 2'(dropped[1]) + 2'(dropped[2]);
    drop_sum = (CNT_WIDTH+2)'(drop_count) + (CNT_WIDTH+2)'(ndrops);
  end

  // Round-robin search starts at the pointer; the pointer only advances on a grant.
  always_comb begin
    order   = '{2'd0, 2'd1, 2'd2};
    found   = 1'b0;
    gidx    = 2'd0;
    drained = '0;
    rr_next = rr_ptr;
    case (rr_ptr)
      SRC_SELF:  order = '{2'd0, 2'd1, 2'd2};
      SRC_RIGHT: order = '{2'd1, 2'd2, 2'd0};
      default:   order = '{2'd2, 2'd0, 2'd1};
    endcase
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && hold_valid[order[k]]) begin
        found = 1'b1;
        gidx  = order[k];
      end
    end
    grant = found && can_push;
    if (grant) begin
      drained[gidx] = 1'b1;
      case (gidx)
        2'd0:    rr_next = SRC_RIGHT;
        2'd1:    rr_next = SRC_LEFT;
        default: rr_next = SRC_SELF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= SRC_SELF;
    else       rr_ptr <= rr_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (drained[i]) hold_valid[i] <= 1'b0;
        if (accept[i] && (!hold_valid[i] || drained[i])) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= in_data[i];
        end
      end
      if (grant) begin
        mem[wr_ptr] <= {gidx, hold_data[gidx]};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({grant, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop_sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) drop_count <= '1;
      else                                          drop_count <= drop_sum[CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_instr_receiver.sv
// Self-checking bench for instr_receiver: directed scenarios plus random traffic
// compared against a queue-based model of the receiver.
module tb_instr_receiver;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        check_self = 1'b0, check_right = 1'b0, check_left = 1'b0;
  logic [31:0] instr_self = '0, instr_right = '0, instr_left = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [1:0]  out_src;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_fail = 0;

  // model: one optional held word per source, FIFO of {src,instr}, RR pointer, drops
  int          hv [3];
  logic [31:0] hd [3];
  logic [33:0] mf [$];
  int          mptr;
  int          mdrop;

  instr_receiver #(.WIDTH(32), .NODE_ADDR(8'h00), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .check_self(check_self), .check_right(check_right), .check_left(check_left),
    .instr_self(instr_self), .instr_right(instr_right), .instr_left(instr_left),
    .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_src(out_src), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] dest, input int low);
    return {dest, 24'(low)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hv[i] = 0;
    mf.delete();
    mptr  = 0;
    mdrop = 0;
  endtask

  task automatic model_step(input logic [2:0] stb, input logic [31:0] d0, d1, d2,
                            input logic rdy);
    logic [31:0] d [3];
    logic        pop_now, can;
    int          g;
    d[0] = d0; d[1] = d1; d[2] = d2;
    pop_now = (mf.size() > 0) && rdy;
    can     = (mf.size() < DEPTH) || pop_now;
    if (pop_now) void'(mf.pop_front());
    g = -1;
    if (can)
      for (int k = 0; k < 3; k++)
        if (g < 0 && hv[(mptr + k) % 3] != 0) g = (mptr + k) % 3;
    if (g >= 0) begin
      mf.push_back({2'(g), hd[g]});
      hv[g] = 0;
      mptr  = (g + 1) % 3;
    end
    for (int i = 0; i < 3; i++)
      if (stb[i] && (d[i][31:24] == 8'h00 || d[i][31:24] == 8'hFF)) begin
        if (hv[i] == 0) begin hv[i] = 1; hd[i] = d[i]; end
        else mdrop = (mdrop < 255) ? mdrop + 1 : 255;
      end
  endtask

  task automatic tick(input logic s, r, l, input logic [31:0] is, ir, il, input logic rdy);
    check_self = s; check_right = r; check_left = l;
    instr_self = is; instr_right = ir; instr_left = il;
    out_ready = rdy;
    @(posedge clk);
    model_step({l, r, s}, is, ir, il, rdy);
    #1;
    check_self = 1'b0; check_right = 1'b0; check_left = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  task automatic do_reset(input logic with_strobes);
    reset = 1'b1;
    check_self = with_strobes; check_right = with_strobes; check_left = with_strobes;
    instr_self = mk(8'h00, 1); instr_right = mk(8'h00, 2); instr_left = mk(8'h00, 3);
    out_ready = with_strobes;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    check_self = 1'b0; check_right = 1'b0; check_left = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_cmp++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0)  begin n_fail++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_cmp++; if (out_src !== 2'b00)    begin n_fail++; $display("FAIL reset_src got %b want 00", out_src); end
    n_cmp++; if (drop_count !== 8'd0)  begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_latency();
    do_reset(1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0000_00AB, '0, '0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", out_valid); end
    idle(1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
    n_cmp++; if (out_instr !== 32'h0000_00AB) begin n_fail++; $display("FAIL lat_instr got %h want 000000ab", out_instr); end
    n_cmp++; if (out_src !== 2'b00) begin n_fail++; $display("FAIL lat_src got %b want 00", out_src); end
    idle(1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pop got %b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b1, mk(8'h00, 16'h10), mk(8'h00, 16'h11), mk(8'h00, 16'h12), 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      want = 2'(i);
      n_cmp++; if (out_valid !== 1'b1 || out_src !== want || out_instr !== mk(8'h00, 16'h10 + i)) begin
        n_fail++; $display("FAIL rr_seq%0d got v=%b src=%b instr=%h want v=1 src=%b instr=%h",
                           i, out_valid, out_src, out_instr, want, mk(8'h00, 16'h10 + i));
      end
      idle(1'b1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap got %b want 0", out_valid); end
    tick(1'b1, 1'b1, 1'b1, mk(8'h00, 16'h20), mk(8'h00, 16'h21), mk(8'h00, 16'h22), 1'b1);
    idle(1'b1);
    n_cmp++; if (out_src !== 2'b00 || out_instr !== mk(8'h00, 16'h20)) begin
      n_fail++; $display("FAIL rr_restart got src=%b instr=%h want src=00 instr=%h", out_src, out_instr, mk(8'h00, 16'h20));
    end
    idle(1'b1); idle(1'b1); idle(1'b1);
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, '0, mk(8'h00, 16'h30 + i), '0, 1'b0);
    idle(1'b0);
    n_cmp++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop got %0d want 1", drop_count); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== mk(8'h00, 16'h30 + i) || out_src !== 2'b01) begin
        n_fail++; $display("FAIL ovf_word%0d got v=%b instr=%h src=%b want v=1 instr=%h src=01",
                           i, out_valid, out_instr, out_src, mk(8'h00, 16'h30 + i));
      end
      idle(1'b1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", out_valid); end
  endtask

  task automatic test_filter();
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b1, mk(8'h05, 1), mk(8'h05, 2), mk(8'h05, 3), 1'b0);
    idle(1'b0); idle(1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL filt_valid got %b want 0", out_valid); end
    n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL filt_drop got %0d want 0", drop_count); end
    tick(1'b0, 1'b0, 1'b1, '0, '0, mk(8'hFF, 16'h77), 1'b0);
    idle(1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== mk(8'hFF, 16'h77) || out_src !== 2'b10) begin
      n_fail++; $display("FAIL filt_bcast got v=%b instr=%h src=%b want v=1 instr=%h src=10",
                         out_valid, out_instr, out_src, mk(8'hFF, 16'h77));
    end
    idle(1'b1);
  endtask

  task automatic test_saturate();
    do_reset(1'b0);
    for (int i = 0; i < 110; i++)
      tick(1'b1, 1'b1, 1'b1, mk(8'h00, i), mk(8'hFF, i), mk(8'h00, i), 1'b0);
    n_cmp++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_drop got %0d want 255", drop_count); end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, mk(8'h00, i), mk(8'h00, i), mk(8'h00, i), 1'b1);
    n_cmp++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", drop_count); end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++)
      tick(1'b1, 1'b1, 1'b1, mk(8'h00, 16'h40 + i), mk(8'h00, 16'h50 + i), mk(8'h00, 16'h60 + i), 1'b0);
    n_cmp++; if (drop_count !== 8'd6) begin n_fail++; $display("FAIL mid_drop got %0d want 6", drop_count); end
    do_reset(1'b1);
    n_cmp++; if (out_valid !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset got v=%b drop=%0d want v=0 drop=0", out_valid, drop_count);
    end
    tick(1'b0, 1'b0, 1'b1, '0, '0, mk(8'h00, 16'h99), 1'b0);
    idle(1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'b10 || out_instr !== mk(8'h00, 16'h99)) begin
      n_fail++; $display("FAIL mid_after got v=%b src=%b instr=%h want v=1 src=10 instr=%h",
                         out_valid, out_src, out_instr, mk(8'h00, 16'h99));
    end
    idle(1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [7:0] dest;
    case ($urandom_range(0, 3))
      0:       dest = 8'h00;
      1:       dest = 8'hFF;
      2:       dest = 8'h05;
      default: dest = 8'($urandom);
    endcase
    return {dest, 24'($urandom)};
  endfunction

  task automatic test_random();
    logic        exp_v;
    logic [33:0] head;
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
           rand_instr(), rand_instr(), rand_instr(), ($urandom_range(0, 3) != 0) || (c > 380));
      exp_v = (mf.size() > 0);
      head  = exp_v ? mf[0] : 34'd0;
      n_cmp++; if (out_valid !== exp_v || out_instr !== head[31:0] || out_src !== head[33:32] ||
                   drop_count !== 8'(mdrop)) begin
        n_fail++; $display("FAIL rand_c%0d got v=%b instr=%h src=%b drop=%0d want v=%b instr=%h src=%b drop=%0d",
                           c, out_valid, out_instr, out_src, drop_count, exp_v, head[31:0], head[33:32], mdrop);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_filter();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
